// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and parameter defaults for the hazard/forwarding unit.
//   DATA_W_DEF / RA_W_DEF / DEPTH_DEF / CNT_W_DEF : defaults for the top-level parameters.
//   RA_W_MAX    : widest register address a table entry can hold.
//   tbl_entry_t : one tracking-table entry {valid, wreg, load, dest}.
package hazard_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned RA_W_DEF   = 4;
    localparam int unsigned DEPTH_DEF  = 3;
    localparam int unsigned CNT_W_DEF  = 16;

    // Entries store dest at a fixed width so the struct needs no parameters; narrower
    // addresses are zero-extended on the way in and compared at this width.
    localparam int unsigned RA_W_MAX = 8;

    typedef logic [RA_W_MAX-1:0] reg_addr_t;

    typedef struct packed {
        logic      valid;
        logic      wreg;
        logic      load;
        reg_addr_t dest;
    } tbl_entry_t;

    localparam tbl_entry_t BUBBLE = '0;

endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: picks the youngest in-flight result for one source operand.
//   ent_valid/ent_wreg : per-stage valid and writes-register flags (bit k = stage k).
//   ent_dest           : per-stage destination addresses, DEST_W bits per stage.
//   src                : source register being read in decode.
//   stg_res            : per-stage results, DATA_W bits per stage.
//   rf_data            : register-file data used when no stage matches.
//   opnd               : selected operand.
module fwd_mux #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEST_W = 8,
    parameter int unsigned DEPTH  = 3
) (
    input  logic [DEPTH-1:0]        ent_valid,
    input  logic [DEPTH-1:0]        ent_wreg,
    input  logic [DEPTH*DEST_W-1:0] ent_dest,
    input  logic [DEST_W-1:0]       src,
    input  logic [DEPTH*DATA_W-1:0] stg_res,
    input  logic [DATA_W-1:0]       rf_data,
    output logic [DATA_W-1:0]       opnd
);

    logic found;

    // Stage 0 is the youngest producer, so the first hit in ascending order wins.
    always_comb begin
        opnd  = rf_data;
        found = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (!found && ent_valid[k] && ent_wreg[k] &&
                (ent_dest[k*DEST_W +: DEST_W] == src)) begin
                opnd  = stg_res[k*DATA_W +: DATA_W];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: load-use stall detection and operand forwarding for an in-order pipe.
//   clk, rst (async, active low)
//   id_*            : decode-stage instruction (valid, wreg, load, dest, sources and use flags)
//   rf_a, rf_b      : register-file read data
//   stg_res         : current result of each tracked stage (slot 0 = execute)
//   jump            : taken branch resolved in stage 0; drops the decode instruction
//   cnt_clr         : synchronous clear of the performance counters
//   opnd_a, opnd_b  : forwarded operands
//   stall, issue    : hold decode / decode instruction enters stage 0
//   stall_cnt, flush_cnt : saturating performance counters
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned RA_W   = RA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic                    id_wreg,
    input  logic                    id_load,
    input  logic [RA_W-1:0]         id_dest,
    input  logic [RA_W-1:0]         id_ra,
    input  logic [RA_W-1:0]         id_rb,
    input  logic                    id_use_a,
    input  logic                    id_use_b,
    input  logic [DATA_W-1:0]       rf_a,
    input  logic [DATA_W-1:0]       rf_b,
    input  logic [DEPTH*DATA_W-1:0] stg_res,
    input  logic                    jump,
    input  logic                    cnt_clr,
    output logic [DATA_W-1:0]       opnd_a,
    output logic [DATA_W-1:0]       opnd_b,
    output logic                    stall,
    output logic                    issue,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        flush_cnt
);

    tbl_entry_t                table_q [DEPTH];
    tbl_entry_t                table_d [DEPTH];
    reg_addr_t                 ra_ext;
    reg_addr_t                 rb_ext;
    logic                      hazard_a;
    logic                      hazard_b;
    logic                      stall_raw;
    logic [DEPTH-1:0]          ent_valid;
    logic [DEPTH-1:0]          ent_wreg;
    logic [DEPTH*RA_W_MAX-1:0] ent_dest;
    logic [CNT_W-1:0]          stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]          flush_cnt_q, flush_cnt_d;
    logic                      unused_last_load;

    assign ra_ext = reg_addr_t'(id_ra);
    assign rb_ext = reg_addr_t'(id_rb);

    // Only a load in stage 0 has no result yet; every later producer can be forwarded.
    assign hazard_a  = id_use_a && (ra_ext == table_q[0].dest);
    assign hazard_b  = id_use_b && (rb_ext == table_q[0].dest);
    assign stall_raw = id_valid && !jump && table_q[0].valid && table_q[0].wreg &&
                       table_q[0].load && (hazard_a || hazard_b);

    // Keep decode quiet while reset is held, even with a valid instruction presented.
    assign stall = rst && stall_raw;
    assign issue = rst && id_valid && !stall_raw && !jump;

    // The oldest entry leaves the table, so its load flag is never consulted.
    assign unused_last_load = table_q[DEPTH-1].load;

    always_comb begin
        table_d[0] = BUBBLE;
        if (issue) begin
            table_d[0].valid = 1'b1;
            table_d[0].wreg  = id_wreg;
            table_d[0].load  = id_load;
            table_d[0].dest  = reg_addr_t'(id_dest);
        end
        for (int unsigned k = 1; k < DEPTH; k++) begin
            table_d[k] = table_q[k-1];
        end
    end

    always_comb begin
        ent_valid = '0;
        ent_wreg  = '0;
        ent_dest  = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            ent_valid[k]                        = table_q[k].valid;
            ent_wreg[k]                         = table_q[k].wreg;
            ent_dest[k*RA_W_MAX +: RA_W_MAX]    = table_q[k].dest;
        end
    end

    fwd_mux #(
        .DATA_W (DATA_W),
        .DEST_W (RA_W_MAX),
        .DEPTH  (DEPTH)
    ) u_fwd_a (
        .ent_valid (ent_valid),
        .ent_wreg  (ent_wreg),
        .ent_dest  (ent_dest),
        .src       (ra_ext),
        .stg_res   (stg_res),
        .rf_data   (rf_a),
        .opnd      (opnd_a)
    );

    fwd_mux #(
        .DATA_W (DATA_W),
        .DEST_W (RA_W_MAX),
        .DEPTH  (DEPTH)
    ) u_fwd_b (
        .ent_valid (ent_valid),
        .ent_wreg  (ent_wreg),
        .ent_dest  (ent_dest),
        .src       (rb_ext),
        .stg_res   (stg_res),
        .rf_data   (rf_b),
        .opnd      (opnd_b)
    );

    // Saturating counters; clear wins over increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall && !(&stall_cnt_q)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (jump && !(&flush_cnt_q)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                table_q[k] <= BUBBLE;
            end
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                table_q[k] <= table_d[k];
            end
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed scenarios on a DEPTH=3 / CNT_W=4 instance, then a
// random stream compared cycle by cycle on DEPTH=3, DEPTH=2 and DEPTH=8 instances against an
// issue-log model (stage k holds whatever issued k+1 cycles ago).
module tb_hazard_forward_unit;

    localparam int NRAND = 400;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          id_valid, id_wreg, id_load, id_use_a, id_use_b, jump, cnt_clr;
    logic [3:0]    id_dest, id_ra, id_rb;
    logic [31:0]   rf_a, rf_b;
    logic [255:0]  stg_res;

    logic          stall_v [3];
    logic          issue_v [3];
    logic [31:0]   oa_v    [3];
    logic [31:0]   ob_v    [3];
    logic [3:0]    sc3, fc3;
    logic [15:0]   sc2, fc2, sc8, fc8;

    // Index 0: DEPTH=3/CNT_W=4, index 1: DEPTH=2, index 2: DEPTH=8.
    hazard_forward_unit #(.DATA_W(32), .RA_W(4), .DEPTH(3), .CNT_W(4)) u_d3 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_wreg(id_wreg), .id_load(id_load),
        .id_dest(id_dest), .id_ra(id_ra), .id_rb(id_rb), .id_use_a(id_use_a),
        .id_use_b(id_use_b), .rf_a(rf_a), .rf_b(rf_b), .stg_res(stg_res[95:0]),
        .jump(jump), .cnt_clr(cnt_clr), .opnd_a(oa_v[0]), .opnd_b(ob_v[0]),
        .stall(stall_v[0]), .issue(issue_v[0]), .stall_cnt(sc3), .flush_cnt(fc3)
    );

    hazard_forward_unit #(.DATA_W(32), .RA_W(4), .DEPTH(2), .CNT_W(16)) u_d2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_wreg(id_wreg), .id_load(id_load),
        .id_dest(id_dest), .id_ra(id_ra), .id_rb(id_rb), .id_use_a(id_use_a),
        .id_use_b(id_use_b), .rf_a(rf_a), .rf_b(rf_b), .stg_res(stg_res[63:0]),
        .jump(jump), .cnt_clr(cnt_clr), .opnd_a(oa_v[1]), .opnd_b(ob_v[1]),
        .stall(stall_v[1]), .issue(issue_v[1]), .stall_cnt(sc2), .flush_cnt(fc2)
    );

    hazard_forward_unit #(.DATA_W(32), .RA_W(4), .DEPTH(8), .CNT_W(16)) u_d8 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_wreg(id_wreg), .id_load(id_load),
        .id_dest(id_dest), .id_ra(id_ra), .id_rb(id_rb), .id_use_a(id_use_a),
        .id_use_b(id_use_b), .rf_a(rf_a), .rf_b(rf_b), .stg_res(stg_res),
        .jump(jump), .cnt_clr(cnt_clr), .opnd_a(oa_v[2]), .opnd_b(ob_v[2]),
        .stall(stall_v[2]), .issue(issue_v[2]), .stall_cnt(sc8), .flush_cnt(fc8)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic       v;
        logic       w;
        logic       l;
        logic [3:0] d;
    } ent_t;

    ent_t lg [3][NRAND];
    int   dep     [3] = '{3, 2, 8};
    int   cnt_max [3] = '{15, 65535, 65535};
    int   exp_sc  [3];
    int   exp_fc  [3];
    int   cyc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic w, input logic l, input int dest,
                          input logic ua, input int ra, input logic ub, input int rb);
        id_valid = v;
        id_wreg  = w;
        id_load  = l;
        id_dest  = 4'(dest);
        id_use_a = ua;
        id_ra    = 4'(ra);
        id_use_b = ub;
        id_rb    = 4'(rb);
    endtask

    task automatic set_res(input int k, input logic [31:0] val);
        stg_res[k*32 +: 32] = val;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] obs_sc(input int d);
        if (d == 0) return {12'd0, sc3};
        if (d == 1) return sc2;
        return sc8;
    endfunction

    function automatic logic [15:0] obs_fc(input int d);
        if (d == 0) return {12'd0, fc3};
        if (d == 1) return fc2;
        return fc8;
    endfunction

    // Instruction that issued k+1 cycles ago (bubble if before the stream started).
    function automatic ent_t stage_ent(input int d, input int k);
        int idx;
        idx = cyc - 1 - k;
        if (idx < 0) return '0;
        return lg[d][idx];
    endfunction

    function automatic logic [31:0] model_fwd(input int d, input logic [3:0] src,
                                              input logic [31:0] rf);
        ent_t e;
        for (int k = 0; k < dep[d]; k++) begin
            e = stage_ent(d, k);
            if (e.v && e.w && e.d == src) return stg_res[k*32 +: 32];
        end
        return rf;
    endfunction

    initial begin
        logic       exp_st, exp_is;
        ent_t       e0;

        rst = 1'b0;
        jump = 1'b0;
        cnt_clr = 1'b0;
        rf_a = 32'hA0A0_0001;
        rf_b = 32'hB0B0_0002;
        for (int k = 0; k < 8; k++) set_res(k, 32'h100 + 32'(k));
        set_id(1, 1, 1, 5, 1, 5, 0, 0);

        // Reset state: outputs quiet even with a valid decode instruction.
        #2;
        chk("rst_issue", issue_v[0], 0);
        chk("rst_stall", stall_v[0], 0);
        chk("rst_opnd_a", oa_v[0], rf_a);
        chk("rst_opnd_b", ob_v[0], rf_b);
        chk("rst_stall_cnt", sc3, 0);
        chk("rst_flush_cnt", fc3, 0);
        tick();
        chk("rst_issue_held", issue_v[0], 0);

        @(negedge clk);
        rst = 1'b1;

        // Load-use: load r5, then a reader of r5.
        set_id(1, 1, 1, 5, 0, 0, 0, 0);
        #1;
        chk("lu_load_issue", issue_v[0], 1);
        chk("lu_load_stall", stall_v[0], 0);
        tick();
        set_id(1, 1, 0, 6, 1, 5, 0, 0);
        #1;
        chk("lu_stall", stall_v[0], 1);
        chk("lu_stall_issue", issue_v[0], 0);
        tick();
        chk("lu_stall_cnt", sc3, 1);
        set_res(1, 32'hDEAD_BEEF);
        #1;
        chk("lu_stall_released", stall_v[0], 0);
        chk("lu_reissue", issue_v[0], 1);
        chk("lu_fwd_stage1", oa_v[0], 32'hDEAD_BEEF);
        tick();
        chk("lu_stall_cnt_once", sc3, 1);

        // Forwarding priority: r3 in stages 0 and 2, r9 in stage 1.
        set_id(1, 1, 0, 3, 0, 0, 0, 0);
        tick();
        set_id(1, 1, 0, 9, 0, 0, 0, 0);
        tick();
        set_id(1, 1, 0, 3, 0, 0, 0, 0);
        tick();
        set_id(0, 0, 0, 0, 1, 3, 1, 9);
        set_res(0, 32'h11);
        set_res(1, 32'h77);
        set_res(2, 32'h22);
        #1;
        chk("pri_young_a", oa_v[0], 32'h11);
        chk("pri_mid_b", ob_v[0], 32'h77);
        tick();
        chk("pri_s1_a", oa_v[0], 32'h77);
        chk("pri_s2_b", ob_v[0], 32'h22);
        tick();
        chk("pri_s2_only_a", oa_v[0], 32'h22);
        chk("pri_aged_out_b", ob_v[0], rf_b);
        tick();

        // Jump while the load-use condition holds.
        set_id(1, 1, 1, 4, 0, 0, 0, 0);
        tick();
        set_id(1, 1, 0, 10, 1, 4, 0, 0);
        jump = 1'b1;
        #1;
        chk("jmp_stall", stall_v[0], 0);
        chk("jmp_issue", issue_v[0], 0);
        chk("jmp_flush_before", fc3, 0);
        tick();
        jump = 1'b0;
        chk("jmp_flush_cnt", fc3, 1);
        set_id(1, 0, 0, 0, 1, 4, 0, 0);
        #1;
        chk("jmp_bubble_no_stall", stall_v[0], 0);
        chk("jmp_bubble_issue", issue_v[0], 1);
        chk("jmp_load_in_s1", oa_v[0], 32'h77);
        tick();

        // Saturation: a self-dependent load stalls every other cycle.
        set_id(1, 1, 1, 5, 1, 5, 0, 0);
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("sat_stall_%0d", i), stall_v[0], (i % 2 == 1) ? 1 : 0);
            tick();
        end
        chk("sat_stall_cnt", sc3, 15);
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_stall_cnt", sc3, 0);
        chk("clr_flush_cnt", fc3, 0);

        // Mid-operation reset with every stage writing r7.
        jump = 1'b1;
        tick();
        jump = 1'b0;
        chk("pre_rst_flush_cnt", fc3, 1);
        set_id(1, 1, 0, 7, 1, 7, 0, 0);
        tick();
        tick();
        tick();
        set_res(0, 32'h5555);
        #1;
        chk("pre_rst_fwd", oa_v[0], 32'h5555);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_opnd_a", oa_v[0], rf_a);
        chk("mid_rst_issue", issue_v[0], 0);
        chk("mid_rst_flush_cnt", fc3, 0);
        chk("mid_rst_stall_cnt", sc3, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_rst_opnd_a", oa_v[0], rf_a);
        chk("post_rst_issue", issue_v[0], 1);

        // Random stream on all three instances after a fresh reset.
        rst = 1'b0;
        tick();
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
        for (int d = 0; d < 3; d++) begin
            exp_sc[d] = 0;
            exp_fc[d] = 0;
        end
        for (int n = 0; n < NRAND; n++) begin
            set_id(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                   $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
                   $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
                   $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)));
            jump    = ($urandom_range(0, 7) == 0);
            cnt_clr = ($urandom_range(0, 31) == 0);
            rf_a    = $urandom();
            rf_b    = $urandom();
            for (int k = 0; k < 8; k++) set_res(k, $urandom());
            #1;
            for (int d = 0; d < 3; d++) begin
                e0 = stage_ent(d, 0);
                exp_st = id_valid && !jump && e0.v && e0.w && e0.l &&
                         ((id_use_a && id_ra == e0.d) || (id_use_b && id_rb == e0.d));
                exp_is = id_valid && !exp_st && !jump;
                chk($sformatf("r%0d_d%0d_stall", n, dep[d]), stall_v[d], exp_st);
                chk($sformatf("r%0d_d%0d_issue", n, dep[d]), issue_v[d], exp_is);
                if (!exp_st) begin
                    chk($sformatf("r%0d_d%0d_opnd_a", n, dep[d]), oa_v[d],
                        model_fwd(d, id_ra, rf_a));
                    chk($sformatf("r%0d_d%0d_opnd_b", n, dep[d]), ob_v[d],
                        model_fwd(d, id_rb, rf_b));
                end
                chk($sformatf("r%0d_d%0d_stall_cnt", n, dep[d]), obs_sc(d), exp_sc[d]);
                chk($sformatf("r%0d_d%0d_flush_cnt", n, dep[d]), obs_fc(d), exp_fc[d]);
                lg[d][cyc] = exp_is ? ent_t'{1'b1, id_wreg, id_load, id_dest} : ent_t'('0);
                if (cnt_clr) begin
                    exp_sc[d] = 0;
                    exp_fc[d] = 0;
                end else begin
                    if (exp_st && exp_sc[d] < cnt_max[d]) exp_sc[d]++;
                    if (jump && exp_fc[d] < cnt_max[d]) exp_fc[d]++;
                end
            end
            tick();
            cyc++;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
